pixel_streamer: RTL

//   Upstream feeder for the layer-1 fully-connected stage. Buffers one 28x28 MNIST image received as a

---
 rtl/pixel_streamer_pkg.sv | 19 +
 rtl/pixel_buffer_ram.sv | 25 ++
 rtl/pixel_streamer.sv | 115 +++++++++++
 3 files changed

// File: rtl/pixel_streamer_pkg.sv
// rtl/pixel_streamer_pkg.sv - shared sizes and FSM encoding for the layer-1 pixel feeder
package pixel_streamer_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 10;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOADED,
        ST_CLEAR,
        ST_STREAM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pixel_buffer_ram.sv
// rtl/pixel_buffer_ram.sv - single-port image buffer, sync write and sync read
module pixel_buffer_ram #(
    parameter int DEPTH = 784,
    parameter int W     = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - buffers one image from a byte stream and replays it to layer 1
module pixel_streamer
    import pixel_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              start,
    output logic              acc_clear,
    output logic [PIX_W-1:0]  pixel_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              pixel_valid,
    output logic              done,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] wr_cnt;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_rdata;

    // Reads run one address ahead of addr_out so the RAM output register lines up with it.
    assign ram_we   = s_valid && s_ready;
    assign ram_re   = (state == ST_CLEAR) || ((state == ST_STREAM) && (addr_out != LAST_ADDR));
    assign ram_addr = ram_we ? wr_cnt
                    : ((state == ST_CLEAR) ? '0 : addr_out + ADDR_W'(1));

    // Layer 1 accumulates every cycle, so the pixel bus must read zero outside a valid pixel.
    assign pixel_out = pixel_valid ? ram_rdata : '0;

    pixel_buffer_ram #(
        .DEPTH (NUM_PIXELS),
        .W     (PIX_W),
        .AW    (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (s_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_cnt      <= '0;
            s_ready     <= 1'b1;
            acc_clear   <= 1'b0;
            addr_out    <= '0;
            pixel_valid <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            acc_clear <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (s_valid) begin
                        if (wr_cnt == LAST_ADDR) begin
                            wr_cnt  <= '0;
                            s_ready <= 1'b0;
                            state   <= ST_LOADED;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_W'(1);
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_LOADED: begin
                    if (start) begin
                        state     <= ST_CLEAR;
                        acc_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state       <= ST_STREAM;
                    pixel_valid <= 1'b1;
                    addr_out    <= '0;
                end
                ST_STREAM: begin
                    if (addr_out == LAST_ADDR) begin
                        state       <= ST_DONE;
                        pixel_valid <= 1'b0;
                        addr_out    <= '0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        s_ready     <= 1'b1;
                    end else begin
                        addr_out <= addr_out + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    // A new beat starts a fresh image and takes priority over a restream request.
                    if (s_valid) begin
                        wr_cnt <= ADDR_W'(1);
                        state  <= ST_LOAD;
                    end else if (start) begin
                        state     <= ST_CLEAR;
                        acc_clear <= 1'b1;
                        busy      <= 1'b1;
                        s_ready   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
